// File: rtl/regbank_pkg.sv
// regbank_pkg: shared SP opcode encodings and parameter sanity helpers for the register bank.
package regbank_pkg;
    localparam logic [1:0] SP_OP_NONE = 2'b00;
    localparam logic [1:0] SP_OP_INC  = 2'b01;
    localparam logic [1:0] SP_OP_DEC  = 2'b10;

    function automatic int sp_index(input int num_regs);
        return num_regs;
    endfunction

    function automatic bit addr_fits(input int addr_w, input int num_regs);
        return (1 << addr_w) > num_regs;
    endfunction
endpackage

// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard: per-register busy bits with claim/clear and two combinational lookups.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [ADDR_W-1:0] addr2_i,
    output logic              busy1_o,
    output logic              busy2_o
);
    logic [NUM_REGS:0] busy_q, busy_d;

    // Index 0 is never set, so it always reads idle; a claim outranks a clear.
    always_comb begin
        busy_d = busy_q;
        busy_d[0] = 1'b0;
        for (int i = 1; i <= NUM_REGS; i++)
            busy_d[i] = (set_en_i && set_addr_i == ADDR_W'(i)) ? 1'b1 :
                        (clr_en_i && clr_addr_i == ADDR_W'(i)) ? 1'b0 : busy_q[i];
    end

    always_ff @(posedge clk)
        busy_q <= reset ? '0 : busy_d;

    assign busy1_o = (addr1_i <= ADDR_W'(NUM_REGS)) ? busy_q[addr1_i] : 1'b0;
    assign busy2_o = (addr2_i <= ADDR_W'(NUM_REGS)) ? busy_q[addr2_i] : 1'b0;
endmodule

// File: rtl/regbank_sb.sv
// regbank_sb: GPR bank with stack pointer at index NUM_REGS, SP push/pop arithmetic,
// optional write-to-read bypass and a busy scoreboard for pending results.
module regbank_sb
    import regbank_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          NUM_REGS = 16,
    parameter int          ADDR_W   = 5,
    parameter int unsigned SP_RESET = 1023,
    parameter int          BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic signed [DATA_W-1:0] rd_data1,
    output logic signed [DATA_W-1:0] rd_data2,
    output logic                     rd_busy1,
    output logic                     rd_busy2,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic [1:0]               sp_op,
    input  logic [DATA_W-1:0]        sp_step,
    output logic [DATA_W-1:0]        sp_out,
    output logic                     sp_err
);
    localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(sp_index(NUM_REGS));
    localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_RESET);

    if (!addr_fits(ADDR_W, NUM_REGS)) begin : g_bad_addr_w
        $error("regbank_sb: ADDR_W too small to address SP");
    end

    logic [DATA_W-1:0] mem_q [0:NUM_REGS];
    logic [DATA_W-1:0] mem_d [0:NUM_REGS];
    logic              sp_err_q, sp_err_d;
    logic [DATA_W:0]   sp_ext;
    logic              wr_ok, sp_act, byp1, byp2, busy1, busy2;

    assign wr_ok  = wr_en && wr_addr != '0 && wr_addr <= SP_IDX;
    // An explicit SP write shadows any push/pop in the same cycle.
    assign sp_act = (sp_op == SP_OP_INC || sp_op == SP_OP_DEC) && !(wr_ok && wr_addr == SP_IDX);
    assign sp_ext = (sp_op == SP_OP_INC) ? {1'b0, mem_q[NUM_REGS]} + {1'b0, sp_step}
                                         : {1'b0, mem_q[NUM_REGS]} - {1'b0, sp_step};

    always_comb begin
        mem_d    = mem_q;
        sp_err_d = sp_err_q;
        if (sp_act) begin
            mem_d[NUM_REGS] = sp_ext[DATA_W-1:0];
            sp_err_d = sp_err_q | sp_ext[DATA_W];
        end
        if (wr_ok)
            mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= NUM_REGS; i++)
                mem_q[i] <= (i == NUM_REGS) ? SP_RST : '0;
            sp_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            sp_err_q <= sp_err_d;
        end
    end

    regbank_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en_i  (claim_en),
        .set_addr_i(claim_addr),
        .clr_en_i  (wr_en),
        .clr_addr_i(wr_addr),
        .addr1_i   (rd_addr1),
        .addr2_i   (rd_addr2),
        .busy1_o   (busy1),
        .busy2_o   (busy2)
    );

    assign byp1 = (BYPASS != 0) && wr_ok && wr_addr == rd_addr1;
    assign byp2 = (BYPASS != 0) && wr_ok && wr_addr == rd_addr2;

    assign rd_data1 = byp1 ? wr_data : (rd_addr1 <= SP_IDX) ? mem_q[rd_addr1] : '0;
    assign rd_data2 = byp2 ? wr_data : (rd_addr2 <= SP_IDX) ? mem_q[rd_addr2] : '0;
    assign rd_busy1 = !byp1 && busy1;
    assign rd_busy2 = !byp2 && busy2;
    assign sp_out   = mem_q[NUM_REGS];
    assign sp_err   = sp_err_q;
endmodule

// File: tb/tb_regbank_sb.sv
// tb_regbank_sb: random and directed stimulus against a behavioural model, checked via a queue.
module tb_regbank_sb;
    localparam int DW = 32, NR = 16, AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, wr_en, claim_en;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, claim_addr;
    logic [DW-1:0] wr_data, sp_step;
    logic [1:0]    sp_op;
    logic signed [DW-1:0] d1_b, d2_b, d1_n, d2_n;
    logic          b1_b, b2_b, b1_n, b2_n, err_b, err_n;
    logic [DW-1:0] spo_b, spo_n;

    regbank_sb #(.BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1_b), .rd_data2(d2_b), .rd_busy1(b1_b), .rd_busy2(b2_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .sp_op(sp_op), .sp_step(sp_step),
        .sp_out(spo_b), .sp_err(err_b));

    regbank_sb #(.BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1_n), .rd_data2(d2_n), .rd_busy1(b1_n), .rd_busy2(b2_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .sp_op(sp_op), .sp_step(sp_step),
        .sp_out(spo_n), .sp_err(err_n));

    typedef struct {
        logic [DW-1:0] d1b, d2b, d1n, d2n, sp;
        logic          b1b, b2b, b1n, b2n, err;
    } exp_t;

    exp_t q[$];
    int   total = 0, passed = 0;

    logic [DW-1:0] m_reg [0:NR];
    bit            m_busy [0:NR];
    bit            m_err;

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        return (a == 0 || a > NR) ? '0 : m_reg[a];
    endfunction

    function automatic bit m_bz(input logic [AW-1:0] a);
        return (a == 0 || a > NR) ? 1'b0 : m_busy[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i <= NR; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_reg[NR] = 1023;
        m_err     = 1'b0;
    endtask

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        else passed++;
    endtask

    // One cycle: apply inputs, queue what the outputs must show now, then advance the model.
    task automatic step(input bit r, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit ce, input logic [AW-1:0] ca, input logic [1:0] op,
                        input logic [DW-1:0] st, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        bit   wv;
        longint s;
        reset = r; wr_en = we; wr_addr = wa; wr_data = wd; claim_en = ce; claim_addr = ca;
        sp_op = op; sp_step = st; rd_addr1 = a1; rd_addr2 = a2;
        wv = we && wa != 0 && wa <= NR;
        e.d1n = m_rd(a1); e.d2n = m_rd(a2); e.b1n = m_bz(a1); e.b2n = m_bz(a2);
        e.d1b = (wv && wa == a1) ? wd : e.d1n;
        e.d2b = (wv && wa == a2) ? wd : e.d2n;
        e.b1b = (wv && wa == a1) ? 1'b0 : e.b1n;
        e.b2b = (wv && wa == a2) ? 1'b0 : e.b2n;
        e.sp  = m_reg[NR];
        e.err = m_err;
        q.push_back(e);
        if (r) m_reset();
        else begin
            if ((op == 2'b01 || op == 2'b10) && !(wv && wa == NR)) begin
                s = (op == 2'b01) ? longint'(m_reg[NR]) + longint'(st) : longint'(m_reg[NR]) - longint'(st);
                if (s < 0 || s >= 64'h1_0000_0000) m_err = 1'b1;
                m_reg[NR] = DW'(s < 0 ? s + 64'h1_0000_0000 : s);
            end
            if (wv) begin
                m_reg[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (ce && ca != 0 && ca <= NR) m_busy[ca] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, a1, a2);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data1_byp", d1_b, e.d1b);
                chk("rd_data2_byp", d2_b, e.d2b);
                chk("rd_busy1_byp", DW'(b1_b), DW'(e.b1b));
                chk("rd_busy2_byp", DW'(b2_b), DW'(e.b2b));
                chk("rd_data1_nobyp", d1_n, e.d1n);
                chk("rd_data2_nobyp", d2_n, e.d2n);
                chk("rd_busy1_nobyp", DW'(b1_n), DW'(e.b1n));
                chk("rd_busy2_nobyp", DW'(b2_n), DW'(e.b2n));
                chk("sp_out", spo_b, e.sp);
                chk("sp_out_nobyp", spo_n, e.sp);
                chk("sp_err", DW'(err_b), DW'(e.err));
                chk("sp_err_nobyp", DW'(err_n), DW'(e.err));
            end
        end
    end

    initial begin
        logic [AW-1:0] a;
        @(posedge clk); #1;
        reset = 1; wr_en = 0; wr_addr = 0; wr_data = 0; claim_en = 0; claim_addr = 0;
        sp_op = 0; sp_step = 0; rd_addr1 = 0; rd_addr2 = 0;
        @(posedge clk); #1;
        m_reset();
        for (int i = 0; i < 32; i += 2) rd(AW'(i), AW'(i + 1));
        step(0, 1, 3, -5, 0, 0, 2'b00, 0, 3, 0);
        rd(3, 3);
        step(0, 1, 0, 7, 0, 0, 2'b00, 0, 0, 0);
        rd(0, 0);
        step(0, 1, 5, 42, 0, 0, 2'b00, 0, 5, 1);
        rd(5, 5);
        step(0, 0, 0, 0, 1, 7, 2'b00, 0, 7, 7);
        rd(7, 7);
        step(0, 1, 7, 9, 1, 7, 2'b00, 0, 7, 1);
        rd(7, 7);
        step(0, 0, 0, 0, 0, 0, 2'b10, 4, 16, 16);
        rd(16, 0);
        step(0, 1, 16, 2, 0, 0, 2'b00, 0, 16, 0);
        step(0, 0, 0, 0, 0, 0, 2'b10, 4, 16, 0);
        rd(16, 0);
        step(0, 0, 0, 0, 0, 0, 2'b01, 3, 16, 0);
        rd(16, 0);
        step(0, 1, 16, 100, 1, 16, 2'b01, 8, 16, 16);
        rd(16, 16);
        step(0, 1, 9, 77, 1, 9, 2'b10, 1, 9, 16);
        step(1, 1, 4, 55, 1, 4, 2'b10, 2000, 4, 9);
        for (int i = 0; i < 32; i += 2) rd(AW'(i), AW'(i + 1));
        for (int n = 0; n < 600; n++) begin
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(17, 31)) : AW'($urandom_range(0, 16));
            step($urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0, a,
                 ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : $urandom,
                 $urandom_range(0, 2) == 0, AW'($urandom_range(0, 18)), 2'($urandom),
                 ($urandom_range(0, 5) == 0) ? $urandom : DW'($urandom_range(0, 600)),
                 ($urandom_range(0, 2) == 0) ? a : AW'($urandom_range(0, 20)), AW'($urandom_range(0, 20)));
        end
        rd(16, 0);
        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) $display("FAIL queue_drain: got %0d entries expected 0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
